pwm_duty_ctrl: RTL and testbench
================================

# pwm_duty_ctrl

Duty-cycle controller sitting between the board inputs and the 10-step PWM generator (100 MHz clock, 10 MHz PWM, duty in 10 % steps, generator resets to 50 %). It turns raw, bouncing increase/decrease buttons into clean single-cycle step pulses for the generator. It also provides a ramp-to-target mode that steps the generator toward a programmed duty at a fixed rate (soft-start / soft-stop). It keeps a shadow copy of the generator's duty level so it never commands a step past 0 % or 100 %.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required to accept a button level change (≥2).
- STEP_INTERVAL, 1000: clock cycles between ramp steps in ramp mode (≥2).
- MIN_GAP, 4: minimum idle cycles between any two output pulses (≥1).
- DUTY_MAX, 10: highest duty level (100 %).
- DUTY_RESET, 5: shadow level after reset; must equal the generator's reset duty.

- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset, asynchronous assert, active-low.
- btn_inc  in  1  raw increase button, asynchronous to clk.
- btn_dec  in  1  raw decrease button, asynchronous to clk.
- mode  in  1  0 = manual (buttons), 1 = ramp-to-target.
- target_load  in  1  one-cycle strobe; captures target.
- target  in  4  requested duty level 0..15; values >DUTY_MAX clamp to DUTY_MAX.
- inc_pulse  out  1  one-cycle step-up command to the generator.
- dec_pulse  out  1  one-cycle step-down command to the generator.
- duty_level  out  4  shadow duty level 0..DUTY_MAX.
- at_target  out  1  duty_level == captured target.
- busy  out  1  holdoff active or a manual request pending.

## Operation
- Input path per button: 2-FF synchronizer → debouncer → rising-edge detect. The debounced level flips only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing sample clears the counter.
- Reset (async): inc_pulse=0, dec_pulse=0, duty_level=DUTY_RESET, target register=DUTY_RESET, at_target=1, busy=0. Synchronizers, debounced levels, counters and pending register are cleared to 0; state is IDLE.
- FSM states: IDLE → PULSE (one cycle, a pulse is high) → HOLD (MIN_GAP cycles) → IDLE.
- Manual mode (mode=0), on a debounced rising edge:
  - Inc edge: request up. Dec edge: request down.
  - Both edges in the same cycle: both dropped.
  - In IDLE, the request goes straight to PULSE.
  - Otherwise it is stored in a one-entry pending register. Further requests while pending is occupied are dropped. Pending is issued on the first IDLE cycle.
- Ramp mode (mode=1):
  - Button edges ignored; pending cleared.
  - When duty_level ≠ target, the step timer counts in IDLE. When it reaches STEP_INTERVAL−1, one pulse is issued toward target and the timer clears.
  - When duty_level == target, the timer is held at 0.
- Saturation: an up request with duty_level=DUTY_MAX, or a down request with duty_level=0, produces no pulse. It is consumed silently and the FSM stays in IDLE.
- duty_level updates ±1 on the same edge that asserts the pulse.
- inc_pulse and dec_pulse are never high together and never high on consecutive cycles.
- Target load: captured with clamping; effective for the next step decision. A load mid-ramp does not restart the timer.
- Mode change, either direction: step timer and pending register cleared on that edge. A PULSE/HOLD already in progress completes.

## Timing
- First edge that samples raw btn_inc=1 is edge 0. The debounced level rises at edge DEBOUNCE_CYCLES+1. inc_pulse is high for the single cycle after edge DEBOUNCE_CYCLES+2, provided the FSM is in IDLE. dec_pulse follows the same timing.
- Pulses are 1 cycle wide. The next pulse is issued no earlier than MIN_GAP+1 cycles after the previous pulse's cycle.
- Ramp: consecutive steps are spaced STEP_INTERVAL cycles apart (STEP_INTERVAL ≥ MIN_GAP+1 is required by configuration).
- at_target and busy are registered and valid the cycle after the state they reflect.
- Button release, and bounce shorter than DEBOUNCE_CYCLES, generate no pulse.

## Test plan
- Reset: assert rst_n=0 mid-HOLD with a pending request → outputs immediately at reset values, duty_level=5, pending lost; after release there are no pulses.
- Manual step: press btn_inc cleanly (D=16) → one inc_pulse in the cycle after edge 18, duty_level 5→6. A bounce of 10 toggles within 15 cycles before settling still yields exactly one pulse.
- Saturation: 7 clean inc presses from 5 → 5 pulses, duty_level=10, last two presses produce no pulse. Same check at 0 with dec.
- Holdoff/pending: three inc edges 1 cycle apart (debounce bypassed with D=2) → first pulse, second issued after MIN_GAP, third dropped; net +2. Simultaneous inc and dec edge → no pulse.
- Ramp: mode=1, target=2 from 5 → dec_pulse every 1000 cycles, exactly 3 pulses, then at_target=1. Load target=15 mid-ramp → clamped to 10, ramps up, stops at 10.
- Mode switch mid-ramp: mode=1→0 with timer at 500 → no further ramp pulses; buttons active again.

Source files
------------

// File: rtl/pwm_duty_ctrl.sv
// rtl/pwm_duty_ctrl.sv - debounced button / ramp-to-target step controller for the 10-step PWM generator
//
// Turns raw increase/decrease buttons into clean one-cycle step pulses, or in ramp
// mode steps toward a programmed duty at a fixed rate. A shadow copy of the
// generator's duty level keeps every command inside 0..DUTY_MAX.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   btn_inc      raw increase button (asynchronous)
//   btn_dec      raw decrease button (asynchronous)
//   mode         0 = manual buttons, 1 = ramp-to-target
//   target_load  one-cycle strobe capturing target
//   target       requested duty level, clamped to DUTY_MAX
//   inc_pulse    one-cycle step-up command
//   dec_pulse    one-cycle step-down command
//   duty_level   shadow duty level
//   at_target    registered duty_level == captured target
//   busy         registered holdoff-active or request-pending flag

module pwm_duty_ctrl #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int STEP_INTERVAL   = 1000,
   parameter int MIN_GAP         = 4,
   parameter int DUTY_MAX        = 10,
   parameter int DUTY_RESET      = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  logic       mode,
   input  logic       target_load,
   input  logic [3:0] target,
   output logic       inc_pulse,
   output logic       dec_pulse,
   output logic [3:0] duty_level,
   output logic       at_target,
   output logic       busy
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TM_W = $clog2(STEP_INTERVAL + 1);
   localparam int GP_W = $clog2(MIN_GAP + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TM_W-1:0] TM_LAST = TM_W'(STEP_INTERVAL - 1);
   localparam logic [GP_W-1:0] GP_LAST = GP_W'(MIN_GAP - 1);
   localparam logic [3:0]      LVL_MAX = 4'(DUTY_MAX);
   localparam logic [3:0]      LVL_RST = 4'(DUTY_RESET);

   typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

   state_t          state;
   state_t          state_nxt;

   // Button vectors: bit 0 = increase, bit 1 = decrease.
   logic [1:0]      sync_a;
   logic [1:0]      sync_b;
   logic [1:0]      db_lvl;
   logic [1:0]      db_prev;
   logic [DB_W-1:0] db_cnt [2];
   logic [1:0]      rise;

   logic            mode_q;
   logic            mode_chg;
   logic            pend_vld;
   logic            pend_up;
   logic [TM_W-1:0] timer;
   logic [GP_W-1:0] gap_cnt;
   logic [3:0]      tgt_lvl;
   logic [3:0]      tgt_clamped;
   logic            step_up;

   logic            man_req;
   logic            man_up;
   logic            ramp_fire;
   logic            cand_vld;
   logic            cand_up;
   logic            at_limit;
   logic            issue;

   // Synchronizer, debouncer and rising-edge detect per button.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a    <= '0;
         sync_b    <= '0;
         db_lvl    <= '0;
         db_prev   <= '0;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         sync_a  <= {btn_dec, btn_inc};
         sync_b  <= sync_a;
         db_prev <= db_lvl;
         for (int i = 0; i < 2; i++) begin
            if (sync_b[i] == db_lvl[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db_lvl[i] <= sync_b[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign rise     = db_lvl & ~db_prev;
   assign mode_chg = mode ^ mode_q;

   // Simultaneous inc and dec edges cancel each other.
   assign man_req  = !mode && (rise[0] ^ rise[1]);
   assign man_up   = rise[0];

   assign ramp_fire   = mode && mode_q && (timer == TM_LAST) && (duty_level != tgt_lvl);
   assign tgt_clamped = (target > LVL_MAX) ? LVL_MAX : target;

   // Request arbitration: pending first, then a fresh button edge, then the ramp step.
   always_comb begin
      cand_vld = 1'b0;
      cand_up  = 1'b0;
      if (pend_vld && !mode) begin
         cand_vld = 1'b1;
         cand_up  = pend_up;
      end else if (man_req) begin
         cand_vld = 1'b1;
         cand_up  = man_up;
      end else if (ramp_fire) begin
         cand_vld = 1'b1;
         cand_up  = (tgt_lvl > duty_level);
      end
   end

   // A saturated request is consumed in IDLE without producing a pulse.
   assign at_limit = cand_up ? (duty_level == LVL_MAX) : (duty_level == 4'd0);
   assign issue    = (state == IDLE) && cand_vld && !at_limit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (issue) state_nxt = PULSE;
         PULSE:   state_nxt = HOLD;
         HOLD:    if (gap_cnt == GP_LAST) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      inc_pulse = 1'b0;
      dec_pulse = 1'b0;
      if (state == PULSE) begin
         inc_pulse = step_up;
         dec_pulse = !step_up;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_cnt    <= '0;
         step_up    <= 1'b0;
         duty_level <= LVL_RST;
         tgt_lvl    <= LVL_RST;
         mode_q     <= 1'b0;
         pend_vld   <= 1'b0;
         pend_up    <= 1'b0;
         timer      <= '0;
         at_target  <= 1'b1;
         busy       <= 1'b0;
      end else begin
         mode_q <= mode;

         if (state == PULSE) begin
            gap_cnt <= '0;
         end else if (state == HOLD) begin
            gap_cnt <= gap_cnt + 1'b1;
         end

         if (issue) begin
            step_up    <= cand_up;
            duty_level <= cand_up ? duty_level + 4'd1 : duty_level - 4'd1;
         end

         if (target_load) begin
            tgt_lvl <= tgt_clamped;
         end

         // Pending is consumed (issued or dropped) on any IDLE cycle; outside IDLE
         // only the first request is kept.
         if (mode || mode_chg || state == IDLE) begin
            pend_vld <= 1'b0;
         end else if (man_req && !pend_vld) begin
            pend_vld <= 1'b1;
            pend_up  <= man_up;
         end

         // The timer runs in every state so ramp steps stay STEP_INTERVAL apart;
         // it waits at its last value until the FSM is back in IDLE.
         if (mode_chg || !mode || duty_level == tgt_lvl) begin
            timer <= '0;
         end else if (state == IDLE && timer == TM_LAST) begin
            timer <= '0;
         end else if (timer != TM_LAST) begin
            timer <= timer + 1'b1;
         end

         at_target <= (duty_level == tgt_lvl);
         busy      <= (state != IDLE) || pend_vld;
      end
   end

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// tb/tb_pwm_duty_ctrl.sv - scoreboard testbench for pwm_duty_ctrl

module tb_pwm_duty_ctrl;

   localparam int D    = 4;
   localparam int SI   = 100;
   localparam int G    = 20;
   localparam int DMAX = 10;
   localparam int DRST = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_inc = 1'b0;
   logic       btn_dec = 1'b0;
   logic       mode = 1'b0;
   logic       target_load = 1'b0;
   logic [3:0] target = 4'd0;
   logic       inc_pulse;
   logic       dec_pulse;
   logic [3:0] duty_level;
   logic       at_target;
   logic       busy;

   pwm_duty_ctrl #(
      .DEBOUNCE_CYCLES(D),
      .STEP_INTERVAL(SI),
      .MIN_GAP(G),
      .DUTY_MAX(DMAX),
      .DUTY_RESET(DRST)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn_inc(btn_inc),
      .btn_dec(btn_dec),
      .mode(mode),
      .target_load(target_load),
      .target(target),
      .inc_pulse(inc_pulse),
      .dec_pulse(dec_pulse),
      .duty_level(duty_level),
      .at_target(at_target),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int t;
      bit up;
      int lvl;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   // Reference model state: shadow duty, captured target, last pulse cycle and
   // the decision cycle of an outstanding pending request.
   int   m_duty = DRST;
   int   m_tgt = DRST;
   int   m_lp = -1000;
   int   m_pend_dc = -1000;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
      end
   endtask

   function automatic bit sat(input bit up);
      return up ? (m_duty == DMAX) : (m_duty == 0);
   endfunction

   task automatic push_pulse(input int t, input bit up);
      m_duty += up ? 1 : -1;
      exp_q.push_back('{t, up, m_duty});
      m_lp = t;
   endtask

   // p: cycle in which the pulse appears if the FSM is free. A pulse at cycle L
   // leaves the FSM free to decide again at L+G+1.
   task automatic model_request(input int p, input bit up);
      int dc;
      dc = p - 1;
      if (dc <= m_pend_dc) return;
      if (dc >= m_lp + G + 1) begin
         if (!sat(up)) push_pulse(p, up);
      end else begin
         m_pend_dc = m_lp + G + 1;
         if (!sat(up)) push_pulse(m_pend_dc + 1, up);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_btn(input bit up, input bit v);
      if (up) btn_inc = v;
      else btn_dec = v;
   endtask

   task automatic press(input bit up, input int h, input int l, input bit modeled);
      set_btn(up, 1'b1);
      if (modeled) model_request(cyc + D + 3, up);
      wait_cyc(h);
      set_btn(up, 1'b0);
      wait_cyc(l);
   endtask

   task automatic bounce_press(input bit up);
      for (int i = 0; i < 10; i++) begin
         set_btn(up, (i % 2) == 0);
         wait_cyc($urandom_range(1, D - 1));
      end
      set_btn(up, 1'b1);
      model_request(cyc + D + 3, up);
      wait_cyc(2 * D + 4);
      set_btn(up, 1'b0);
      wait_cyc(D + 2);
   endtask

   task automatic load(input int v, output int l);
      target = 4'(v);
      target_load = 1'b1;
      l = cyc;
      m_tgt = (v > DMAX) ? DMAX : v;
      wait_cyc(1);
      target_load = 1'b0;
   endtask

   task automatic settle(input string name, input int n);
      wait_cyc(n);
      check({name, "_missing_pulses"}, exp_q.size(), 0);
      exp_q.delete();
      check({name, "_duty_level"}, int'(duty_level), m_duty);
      check({name, "_at_target"}, int'(at_target), int'(m_duty == m_tgt));
   endtask

   exp_t mon_e;
   bit   prev_pulse = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (inc_pulse || dec_pulse) begin
            check("pulse_exclusive", int'(inc_pulse & dec_pulse), 0);
            check("pulse_back_to_back", int'(prev_pulse), 0);
            if (exp_q.size() == 0) begin
               check("unexpected_pulse_cycle", cyc, -1);
            end else begin
               mon_e = exp_q.pop_front();
               check("pulse_cycle", cyc, mon_e.t);
               check("pulse_dir_up", int'(inc_pulse), int'(mon_e.up));
               check("pulse_duty", int'(duty_level), mon_e.lvl);
            end
         end
         prev_pulse = inc_pulse || dec_pulse;
      end else begin
         prev_pulse = 1'b0;
      end
   end

   initial begin
      int L;
      int n;
      int v;
      bit up;

      // Reset values.
      wait_cyc(3);
      check("rst_inc_pulse", int'(inc_pulse), 0);
      check("rst_dec_pulse", int'(dec_pulse), 0);
      check("rst_duty_level", int'(duty_level), DRST);
      check("rst_at_target", int'(at_target), 1);
      check("rst_busy", int'(busy), 0);
      rst_n = 1'b1;
      wait_cyc(5);

      // Reset in the middle of HOLD with a pending request.
      press(1'b1, 5, 5, 1'b1);
      press(1'b1, 5, 5, 1'b1);
      check("hold_busy", int'(busy), 1);
      check("hold_pending_outstanding", exp_q.size(), 1);
      rst_n = 1'b0;
      #1;
      check("midrst_inc_pulse", int'(inc_pulse), 0);
      check("midrst_dec_pulse", int'(dec_pulse), 0);
      check("midrst_duty_level", int'(duty_level), DRST);
      check("midrst_at_target", int'(at_target), 1);
      check("midrst_busy", int'(busy), 0);
      exp_q.delete();
      m_duty = DRST;
      m_tgt = DRST;
      m_lp = -1000;
      m_pend_dc = -1000;
      @(negedge clk);
      wait_cyc(2);
      rst_n = 1'b1;
      settle("after_reset", 80);

      // Clean press and bounced press.
      press(1'b1, D + 3, D + 3, 1'b1);
      settle("clean_press", 40);
      bounce_press(1'b1);
      settle("bounce_press", 40);

      // Saturation at the top and at the bottom.
      repeat (5) press(1'b1, D + 2, 30, 1'b1);
      settle("sat_top", 40);
      repeat (12) press(1'b0, D + 2, 30, 1'b1);
      settle("sat_bottom", 40);

      // Holdoff: second request pends, third is dropped.
      repeat (3) press(1'b1, 5, 5, 1'b1);
      settle("holdoff", 60);

      // Simultaneous inc and dec edges.
      btn_inc = 1'b1;
      btn_dec = 1'b1;
      wait_cyc(D + 3);
      btn_inc = 1'b0;
      btn_dec = 1'b0;
      settle("simultaneous", 40);

      // Randomized manual presses.
      repeat (20) begin
         up = 1'($urandom_range(0, 1));
         press(up, D + $urandom_range(0, 4), D + 1 + $urandom_range(0, 25), 1'b1);
      end
      settle("random_manual", 60);

      // Ramp toward a low target.
      v = (m_duty == 2) ? 8 : 2;
      load(v, L);
      wait_cyc(5);
      mode = 1'b1;
      L = cyc;
      n = (m_duty > v) ? m_duty - v : v - m_duty;
      up = (v > m_duty);
      for (int k = 1; k <= n; k++) push_pulse(L + 1 + SI * k, up);
      settle("ramp_first", n * SI + 30);

      // Load mid-ramp: the step grid continues, direction follows the new target.
      load(0, L);
      push_pulse(L + 1 + SI, 1'b0);
      wait_cyc(SI + 36);
      load(15, v);
      n = DMAX - m_duty;
      for (int k = 2; k <= n + 1; k++) push_pulse(L + 1 + SI * k, 1'b1);
      settle("ramp_reload", n * SI + 30);

      // Randomized targets in ramp mode; button presses are ignored.
      repeat (3) begin
         v = $urandom_range(0, 15);
         load(v, L);
         n = (m_duty > m_tgt) ? m_duty - m_tgt : m_tgt - m_duty;
         up = (m_tgt > m_duty);
         for (int k = 1; k <= n; k++) push_pulse(L + 1 + SI * k, up);
         press(1'b1, D + 2, D + 2, 1'b0);
         settle("ramp_random", n * SI + 30);
      end

      // Mode switch mid-ramp stops ramp steps and re-enables buttons.
      v = (m_duty > 5) ? 0 : 10;
      load(v, L);
      push_pulse(L + 1 + SI, (v == 10));
      wait_cyc(SI + 50);
      mode = 1'b0;
      settle("mode_switch", 3 * SI);
      press(1'b1, D + 2, D + 2, 1'b1);
      settle("manual_after_switch", 40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
